// File: rtl/exp_job_sequencer.sv
// exp_job_sequencer: buffers operands in a FIFO and runs them one at a time through the exponential engine.
// Define EXP_TIMEOUT_EN to add a WAIT-state watchdog that returns 18'h3FFFF with out_err set.
module exp_job_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    output logic        eng_start,
    output logic [15:0] eng_x,
    input  logic        eng_done,
    input  logic [1:0]  eng_int,
    input  logic [15:0] eng_frac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_result,
    output logic        out_err,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, ARM = 2'd2, WAIT = 2'd3;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("exp_job_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]    state;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_nxt;
    logic          push, pop, capture, timeout;

    assign push      = in_valid && in_ready;
    // a new job may leave IDLE in the same cycle the previous result is consumed
    assign pop       = state == IDLE && count != '0 && (!out_valid || out_ready);
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    assign eng_start = state == START;
    assign busy      = count != '0 || state != IDLE || out_valid;
    assign capture   = state == WAIT && (eng_done || timeout);

`ifdef EXP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    assign timeout = wait_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) wait_cnt <= '0;
        else wait_cnt <= wait_cnt + CW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count    <= count_nxt;
            in_ready <= count_nxt != (AW+1)'(FIFO_DEPTH);
        end
    end

    // ARM exists only to let a stale level-type done from the previous job drain
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            eng_x      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
        end else begin
            state <= pop ? START : state == START ? ARM : state == ARM ? WAIT : capture ? IDLE : state;
            if (pop) eng_x <= mem[rptr];
            if (capture) begin
                out_valid  <= 1'b1;
                out_result <= eng_done ? {eng_int, eng_frac} : 18'h3FFFF;
                out_err    <= !eng_done;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exp_job_sequencer.sv
// tb_exp_job_sequencer: directed bench with a bench-side engine and a queue-based model of the sequencer.
module tb_exp_job_sequencer;
    localparam int DEPTH = 4, TO = 16;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready;
    logic [15:0] in_x = 0;
    logic        eng_start;
    logic [15:0] eng_x;
    logic        eng_done = 0;
    logic [1:0]  eng_int = 0;
    logic [15:0] eng_frac = 0;
    logic        out_valid, out_ready = 0;
    logic [17:0] out_result;
    logic        out_err, busy;

    exp_job_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done), .eng_int(eng_int),
        .eng_frac(eng_frac), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] fres(input logic [15:0] x);
        return x == 16'h8000 ? 18'h1A612 : x == 16'hC000 ? 18'h21DF5 : {2'b01, x ^ 16'h5A5A};
    endfunction

    function automatic bit never(input logic [15:0] x);
        return x == 16'hBEEF;
    endfunction

    // bench engine: done eng_lat cycles after start; in hold mode done stays high until the next start's ARM cycle
    int eng_lat = 20;
    bit eng_hold = 0;
    int done_at = -1, drop_at = -1;
    logic [15:0] ex;
    initial forever begin
        @(posedge clk);
        #1;
        if (eng_start) begin
            drop_at = cyc + 2;
            if (!never(eng_x)) begin
                done_at = cyc + eng_lat;
                ex = eng_x;
            end
        end
        if (cyc == done_at) begin
            eng_done = 1;
            {eng_int, eng_frac} = fres(ex);
        end else if (!eng_hold || cyc == drop_at) begin
            eng_done = 0;
        end
    end

    // model: accepted-not-started operands, started-not-consumed jobs, and the one pending capture
    logic [15:0] acc_q[$], inf_q[$], xs;
    logic [17:0] got_q[$];
    logic [17:0] cap_res, m_res;
    logic        cap_err, m_err, m_valid = 0, prev_start = 0;
    int          cap_at = -1, occ;
    bit          chk_en = 0;

    always @(negedge clk) begin
        if (chk_en && rst) begin
            acc_q.delete();
            inf_q.delete();
            m_valid = 0;
            cap_at = -1;
            prev_start = 0;
        end else if (chk_en) begin
            if (eng_start) begin
                chk("start_src", acc_q.size() != 0, 1);
                if (acc_q.size() != 0) chk("start_order", eng_x, acc_q[0]);
                chk("start_after_consume", inf_q.size(), 0);
                chk("start_pulse", prev_start, 0);
                xs = acc_q.size() != 0 ? acc_q.pop_front() : eng_x;
                inf_q.push_back(xs);
                cap_at  = never(xs) ? cyc + TO + 1 : cyc + eng_lat;
                cap_res = never(xs) ? 18'h3FFFF : fres(xs);
                cap_err = never(xs);
            end
            occ = acc_q.size();
            chk("in_ready", in_ready, occ < DEPTH);
            chk("busy", busy, occ != 0 || inf_q.size() != 0);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_result", out_result, m_res);
                chk("out_err", out_err, m_err);
            end
            if (inf_q.size() != 0) chk("eng_x_hold", eng_x, inf_q[0]);
            if (in_valid && occ < DEPTH) acc_q.push_back(in_x);
            if (m_valid && out_ready) begin
                got_q.push_back(out_result);
                void'(inf_q.pop_front());
                m_valid = 0;
            end
            if (cyc == cap_at) begin
                m_valid = 1;
                m_res = cap_res;
                m_err = cap_err;
                cap_at = -1;
            end
            prev_start = eng_start;
        end
    end

    int t_acc, t1, t2, n0;

    task automatic push(input logic [15:0] x);
        int n = 0;
        in_valid = 1;
        in_x = x;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("push_bound", in_ready, 1);
        t_acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_for(input bit ov, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ov ? out_valid : eng_start) && n < 500);
        chk(ov ? "wait_out_valid" : "wait_eng_start", ov ? out_valid : eng_start, 1);
        t = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        chk("idle_bound", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_x", eng_x, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_err", out_err, 0);
        @(posedge clk);
        #1;

        // single job
        out_ready = 1;
        eng_lat = 20;
        push(16'h8000);
        wait_for(0, t1);
        chk("start_lat", t1 - t_acc, 2);
        @(negedge clk);
        chk("start_single", eng_start, 0);
        wait_for(1, t2);
        chk("valid_lat", t2 - t1, 21);
        chk("single_result", out_result, 18'h1A612);
        chk("single_err", out_err, 0);
        chk("single_eng_x", eng_x, 16'h8000);
        wait_idle();

        // minimum job period
        eng_lat = 2;
        push(16'hA000);
        push(16'hA100);
        wait_for(0, t1);
        wait_for(0, t2);
        chk("job_period", t2 - t1, 4);
        wait_idle();

        // back-pressure
        eng_lat = 20;
        out_ready = 0;
        n0 = got_q.size();
        push(16'h8000);
        push(16'hC000);
        wait_for(1, t1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_no_start", eng_start, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        wait_idle();
        chk("bp_order0", got_q[n0], 18'h1A612);
        chk("bp_order1", got_q[n0+1], 18'h21DF5);

        // FIFO full
        eng_lat = 30;
        n0 = got_q.size();
        for (int i = 1; i <= 5; i++) push({i[3:0], 12'h000});
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        push(16'h6000);
        wait_idle();
        for (int i = 1; i <= 6; i++) chk("full_order", got_q[n0+i-1], {2'b01, {i[3:0], 12'h000} ^ 16'h5A5A});
        chk("full_first", got_q[n0], 18'h14A5A);

        // stale level-type done
        eng_hold = 1;
        eng_lat = 5;
        n0 = got_q.size();
        push(16'h7000);
        push(16'h7100);
        push(16'h7200);
        wait_idle();
        eng_hold = 0;
        repeat (3) @(negedge clk);
        chk("stale_count", got_q.size() - n0, 3);
        @(posedge clk);
        #1;

        // reset while in WAIT with two queued
        eng_lat = 20;
        n0 = got_q.size();
        push(16'h8100);
        push(16'h8200);
        push(16'h8300);
        repeat (6) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (30) @(negedge clk);
        chk("midrst_no_output", got_q.size() - n0, 0);
        @(posedge clk);
        #1;
        push(16'h9000);
        wait_idle();
        chk("post_rst_result", got_q[got_q.size()-1], 18'h1CA5A);

`ifdef EXP_TIMEOUT_EN
        // engine never answers the first job
        n0 = got_q.size();
        push(16'hBEEF);
        push(16'hB100);
        wait_for(0, t1);
        wait_for(1, t2);
        chk("timeout_lat", t2 - t1, 18);
        chk("timeout_result", out_result, 18'h3FFFF);
        chk("timeout_err", out_err, 1);
        wait_idle();
        chk("timeout_next", got_q[n0+1], 18'h1EB5A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/exp_job_sequencer.md
Name: exp_job_sequencer

Overview:
- Upstream/downstream sequencer for the `exponential` engine.
- Accepts x operands (unsigned 0.16 fractions) over a valid/ready stream and buffers them in a small FIFO.
- Issues them one at a time to the engine via start/done, then returns each {int,frac} result over a valid/ready stream in issue order.
- Sits between the operand source and the result consumer, with the engine instantiated beside it.

Parameters:
- FIFO_DEPTH, 4, operand FIFO entries; power of 2, ≥2.
- TIMEOUT_CYCLES, 4096, WAIT-state cycle limit; used only with EXP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high; shared with the engine.
- in_valid  in  1  operand offered.
- in_ready  out  1  FIFO can accept; equals !full (registered).
- in_x  in  16  operand, 0.16 fraction.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_x  out  16  operand to engine; held stable from pulse until result capture.
- eng_done  in  1  engine done; level or pulse.
- eng_int  in  2  engine integer result.
- eng_frac  in  16  engine fraction result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_result  out  18  {int[1:0], frac[15:0]}.
- out_err  out  1  timeout flag, qualified by out_valid.
- busy  out  1  FIFO non-empty OR state≠IDLE OR out_valid.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. rst sampled high clears FIFO pointers and count, sets state=IDLE, and drives to 0: eng_start, eng_x, out_valid, out_result, out_err, busy. in_ready=1 the cycle after reset.
- FIFO push/pop:
  - Push when in_valid & in_ready.
  - Pop only in IDLE.
  - Simultaneous push and pop leaves count unchanged.
  - A push while full is ignored, even with a pop in the same cycle.
  - A word pushed at cycle N is poppable at N+1.
- State machine:
  - IDLE: if FIFO non-empty AND (out_valid==0 OR out_ready==1), pop, latch eng_x and go to START; else stay.
  - START: eng_start=1 for exactly this cycle, then go to ARM.
  - ARM: eng_done ignored, so a stale level-type done from the prior job cannot be captured. Go to WAIT.
  - WAIT: on eng_done==1, register out_result={eng_int,eng_frac}, set out_valid=1, out_err=0, and go to IDLE.
- Output stream:
  - out_valid falls on the cycle after out_valid & out_ready, unless a new capture occurs that cycle.
  - out_result is stable while out_valid & !out_ready.
- Latency and throughput:
  - Operand accepted at N gives eng_start at N+2.
  - eng_done sampled at M gives out_valid at M+1.
  - Minimum 4 cycles per job plus engine time.
  - The next job may pop in the same cycle the previous result is consumed.
- Ordering: strict FIFO order; results never reorder or drop.
- Reset mid-operation: reset in any state aborts the job. The in-flight operand and all buffered operands are discarded, and no result is emitted.
- eng_done outside WAIT has no effect.

Optional Feature:
- Macro: EXP_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no eng_done, the block emits out_result=18'h3FFFF, out_err=1, out_valid=1, and returns to IDLE.
  - A late eng_done is then ignored (outside WAIT).
  - If eng_done and the limit coincide, done wins.
- Undefined: no counter; WAIT lasts indefinitely; out_err tied 0.

Test Plan:
- Single job: bench engine model returns int=1, frac=16'hA612 on done 20 cycles after start; push in_x=16'h8000 with out_ready=1.
  - Expect a single-cycle eng_start 2 cycles after accept.
  - Expect eng_x=16'h8000 stable through done.
  - Expect out_result=18'h1A612 with out_valid one cycle after done, and out_err=0.
- Back-pressure: push 16'h8000 then 16'hC000; model returns 18'h1A612 then 18'h21DF5; out_ready=0.
  - The second eng_start must not occur while result 1 is unconsumed.
  - Raise out_ready: results appear in order 1A612, 21DF5.
- FIFO full: engine stalled (done=0), push 6 operands 16'h1000..16'h6000 with FIFO_DEPTH=4.
  - The first pops into the engine.
  - Next 4 accepted; in_ready=0 after them and the sixth is held.
  - Release the engine: eng_x sequence matches push order.
- Stale done: model holds eng_done=1 until the next start's second cycle.
  - No capture in ARM; exactly one result per job.
- Reset in WAIT: assert rst for 1 cycle mid-job with 2 queued.
  - Next cycle: out_valid=0, busy=0, in_ready=1.
  - A later eng_done produces no output.
- EXP_TIMEOUT_EN with TIMEOUT_CYCLES=16: engine never responds.
  - Expect out_valid with out_result=18'h3FFFF and out_err=1 about 16 cycles after WAIT entry.
  - The next queued job then starts normally.
